// File: rtl/life_hud_renderer.sv
// HUD life counter: a row of heart icons overlaid on the VGA pixel stream, with
// a blinking flash on the slots that were just lost. Two-stage pixel pipeline.
module life_hud_renderer #(
    parameter int         MAX_LIVES     = 3,
    parameter int         X0            = 16,
    parameter int         Y0            = 8,
    parameter int         SPACING       = 2,
    parameter logic [7:0] FILL_COLOR    = 8'hE0,
    parameter logic [7:0] OUTLINE_COLOR = 8'hFF,
    parameter int         FLASH_FRAMES  = 60,
    parameter int         BLINK_FRAMES  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       video_on,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       frame_tick,
    input  logic [2:0] lives,
    output logic [7:0] rgb_out,
    output logic       hud_on,
    output logic       flash_active
);
    localparam int SPR_W = 14;
    localparam int SPR_H = 10;
    localparam int SW    = SPR_W + SPACING;
    localparam int FC_W  = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam int BC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLASH = 1'b1;

    // Sprite ROM: {outline, interior} bits for one heart pixel.
    function automatic logic [1:0] sprite_px(input logic [3:0] r, input logic [3:0] c);
        logic [15:0] om;
        logic [15:0] im;
        om = 16'h0000;
        im = 16'h0000;
        case (r)
            4'd0: begin om = 16'h0618; im = 16'h0000; end
            4'd1: begin om = 16'h0924; im = 16'h0618; end
            4'd2: begin om = 16'h10C2; im = 16'h0F3C; end
            4'd3: begin om = 16'h1002; im = 16'h0FFC; end
            4'd4: begin om = 16'h1002; im = 16'h0FFC; end
            4'd5: begin om = 16'h0804; im = 16'h07F8; end
            4'd6: begin om = 16'h0408; im = 16'h03F0; end
            4'd7: begin om = 16'h0210; im = 16'h01E0; end
            4'd8: begin om = 16'h0120; im = 16'h00C0; end
            4'd9: begin om = 16'h00C0; im = 16'h0000; end
            default: begin om = 16'h0000; im = 16'h0000; end
        endcase
        return {om[c], im[c]};
    endfunction

    logic [10:0] x_ext;
    logic [10:0] y_ext;
    logic        row_hit;
    logic [3:0]  row_idx;
    logic [MAX_LIVES-1:0] slot_hit;
    logic [3:0]  slot_col [MAX_LIVES];

    assign x_ext   = {1'b0, x};
    assign y_ext   = {1'b0, y};
    assign row_hit = (y_ext >= 11'(Y0)) && (y_ext <= 11'(Y0 + SPR_H - 1));
    assign row_idx = 4'(y_ext - 11'(Y0));

    genvar gi;
    generate
        for (gi = 0; gi < MAX_LIVES; gi++) begin : g_slot
            localparam int LO = X0 + gi * SW;
            assign slot_hit[gi] = (x_ext >= 11'(LO)) && (x_ext <= 11'(LO + SPR_W - 1));
            assign slot_col[gi] = 4'(x_ext - 11'(LO));
        end
    endgenerate

    logic       any_hit;
    logic [2:0] sel_slot;
    logic [3:0] sel_col;

    always_comb begin
        any_hit  = 1'b0;
        sel_slot = 3'd0;
        sel_col  = 4'd0;
        for (int i = 0; i < MAX_LIVES; i++) begin
            if (slot_hit[i]) begin
                any_hit  = 1'b1;
                sel_slot = 3'(i);
                sel_col  = slot_col[i];
            end
        end
    end

    logic       vid_q;
    logic       in_slot_q;
    logic [2:0] slot_q;
    logic [3:0] row_q;
    logic [3:0] col_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            vid_q     <= 1'b0;
            in_slot_q <= 1'b0;
            slot_q    <= 3'd0;
            row_q     <= 4'd0;
            col_q     <= 4'd0;
        end else begin
            vid_q     <= video_on;
            in_slot_q <= any_hit && row_hit;
            slot_q    <= sel_slot;
            row_q     <= row_idx;
            col_q     <= sel_col;
        end
    end

    logic [0:0]      state_q, state_d;
    logic [2:0]      lives_q, lives_d;
    logic [2:0]      flash_lo_q, flash_lo_d;
    logic [2:0]      flash_hi_q, flash_hi_d;
    logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [BC_W-1:0] blink_cnt_q, blink_cnt_d;
    logic            blink_phase_q, blink_phase_d;
    logic [2:0]      lives_new;

    assign lives_new = (lives > 3'(MAX_LIVES)) ? 3'(MAX_LIVES) : lives;

    always_comb begin
        state_d       = state_q;
        lives_d       = lives_q;
        flash_lo_d    = flash_lo_q;
        flash_hi_d    = flash_hi_q;
        frame_cnt_d   = frame_cnt_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_tick) begin
            lives_d = lives_new;
            if (lives_new < lives_q) begin
                // A loss (first or further) restarts the flash; the upper
                // bound is only set on entry so earlier lost slots keep blinking.
                if (state_q == ST_IDLE) begin
                    flash_hi_d = lives_q - 3'd1;
                end
                state_d       = ST_FLASH;
                flash_lo_d    = lives_new;
                frame_cnt_d   = '0;
                blink_cnt_d   = '0;
                blink_phase_d = 1'b0;
            end else if (state_q == ST_FLASH) begin
                if (lives_new > lives_q || frame_cnt_q == FC_W'(FLASH_FRAMES - 1)) begin
                    state_d       = ST_IDLE;
                    frame_cnt_d   = '0;
                    blink_cnt_d   = '0;
                    blink_phase_d = 1'b0;
                end else begin
                    frame_cnt_d = frame_cnt_q + FC_W'(1);
                    if (blink_cnt_q == BC_W'(BLINK_FRAMES - 1)) begin
                        blink_cnt_d   = '0;
                        blink_phase_d = ~blink_phase_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + BC_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            lives_q       <= 3'(MAX_LIVES);
            flash_lo_q    <= 3'd0;
            flash_hi_q    <= 3'd0;
            frame_cnt_q   <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            lives_q       <= lives_d;
            flash_lo_q    <= flash_lo_d;
            flash_hi_q    <= flash_hi_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    logic [1:0] px_class;
    logic       slot_full;
    logic       hud_on_d, hud_on_q;
    logic [7:0] rgb_d, rgb_q;

    assign px_class  = sprite_px(row_q, col_q);
    assign slot_full = (slot_q < lives_q) ||
                       (blink_phase_q && (slot_q >= flash_lo_q) && (slot_q <= flash_hi_q));

    always_comb begin
        hud_on_d = 1'b0;
        rgb_d    = 8'h00;
        if (vid_q && in_slot_q) begin
            if (px_class[1]) begin
                hud_on_d = 1'b1;
                rgb_d    = OUTLINE_COLOR;
            end else if (px_class[0] && slot_full) begin
                hud_on_d = 1'b1;
                rgb_d    = FILL_COLOR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hud_on_q <= 1'b0;
            rgb_q    <= 8'h00;
        end else begin
            hud_on_q <= hud_on_d;
            rgb_q    <= rgb_d;
        end
    end

    assign hud_on       = hud_on_q;
    assign rgb_out      = rgb_q;
    assign flash_active = (state_q == ST_FLASH);

endmodule

// File: tb/tb_life_hud_renderer.sv
// Directed bench for life_hud_renderer: sprite pixels, pipelining, loss flash,
// double loss, abort/clamp and reset during a flash.
module tb_life_hud_renderer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       video_on = 1'b0;
    logic [9:0] x = 10'd0;
    logic [9:0] y = 10'd0;
    logic       frame_tick = 1'b0;
    logic [2:0] lives = 3'd3;
    logic [7:0] rgb_out;
    logic       hud_on;
    logic       flash_active;

    int checks = 0;
    int errors = 0;

    int         bx[10]   = '{19, 20, 16, 30, 28, 22, 22, 44, 45, 62};
    int         by[10]   = '{ 8, 11,  8,  8, 11, 17, 18, 11, 11, 11};
    logic       bon[10]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] brgb[10] = '{8'hFF, 8'hE0, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00};

    always #5 clk = ~clk;

    life_hud_renderer dut (
        .clk          (clk),
        .reset        (reset),
        .video_on     (video_on),
        .x            (x),
        .y            (y),
        .frame_tick   (frame_tick),
        .lives        (lives),
        .rgb_out      (rgb_out),
        .hud_on       (hud_on),
        .flash_active (flash_active)
    );

    task automatic probe(input int px, input int py, input logic vid,
                         output logic on, output logic [7:0] rgb);
        @(negedge clk);
        x = 10'(px);
        y = 10'(py);
        video_on = vid;
        @(posedge clk);
        @(posedge clk);
        #1;
        on  = hud_on;
        rgb = rgb_out;
    endtask

    task automatic tick(input logic [2:0] l);
        @(negedge clk);
        lives = l;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        lives = 3'd3;
        frame_tick = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic on;
        logic [7:0] rgb;
        @(negedge clk);
        reset = 1'b1;
        video_on = 1'b1;
        x = 10'd19;
        y = 10'd8;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (hud_on !== 1'b0 || rgb_out !== 8'h00) begin errors++; $display("FAIL reset_outputs: hud_on=%b rgb=%h, expected 0/00", hud_on, rgb_out); end
        checks++; if (flash_active !== 1'b0) begin errors++; $display("FAIL reset_flash: flash_active=%b, expected 0", flash_active); end
        @(negedge clk);
        reset = 1'b0;
        probe(52, 11, 1'b1, on, rgb);
        checks++; if (on !== 1'b1 || rgb !== 8'hE0) begin errors++; $display("FAIL reset_slot2_full: hud_on=%b rgb=%h, expected 1/e0", on, rgb); end
    endtask

    task automatic test_pixels();
        logic on;
        logic [7:0] rgb;
        probe(19, 8, 1'b1, on, rgb);
        checks++; if (on !== 1'b1 || rgb !== 8'hFF) begin errors++; $display("FAIL outline_19_8: hud_on=%b rgb=%h, expected 1/ff", on, rgb); end
        probe(20, 11, 1'b1, on, rgb);
        checks++; if (on !== 1'b1 || rgb !== 8'hE0) begin errors++; $display("FAIL interior_20_11: hud_on=%b rgb=%h, expected 1/e0", on, rgb); end
        probe(16, 8, 1'b1, on, rgb);
        checks++; if (on !== 1'b0 || rgb !== 8'h00) begin errors++; $display("FAIL transparent_16_8: hud_on=%b rgb=%h, expected 0/00", on, rgb); end
        probe(30, 8, 1'b1, on, rgb);
        checks++; if (on !== 1'b0 || rgb !== 8'h00) begin errors++; $display("FAIL gap_30_8: hud_on=%b rgb=%h, expected 0/00", on, rgb); end
        probe(19, 8, 1'b0, on, rgb);
        checks++; if (on !== 1'b0 || rgb !== 8'h00) begin errors++; $display("FAIL video_off: hud_on=%b rgb=%h, expected 0/00", on, rgb); end
        probe(51, 8, 1'b1, on, rgb);
        checks++; if (on !== 1'b1 || rgb !== 8'hFF) begin errors++; $display("FAIL outline_51_8: hud_on=%b rgb=%h, expected 1/ff", on, rgb); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                checks++;
                if (hud_on !== bon[i-2] || rgb_out !== brgb[i-2])
                    begin errors++; $display("FAIL stream_%0d_%0d: hud_on=%b rgb=%h, expected %b/%h", bx[i-2], by[i-2], hud_on, rgb_out, bon[i-2], brgb[i-2]); end
            end
            if (i < 10) begin
                x = 10'(bx[i]);
                y = 10'(by[i]);
                video_on = 1'b1;
            end
        end
    endtask

    task automatic test_single_flash();
        logic on;
        logic [7:0] rgb;
        logic exp_full;
        logic exp_flash;
        do_reset();
        tick(3'd2);
        checks++; if (flash_active !== 1'b1) begin errors++; $display("FAIL single_enter: flash_active=%b, expected 1", flash_active); end
        probe(52, 11, 1'b1, on, rgb);
        checks++; if (on !== 1'b0 || rgb !== 8'h00) begin errors++; $display("FAIL single_k0_slot2: hud_on=%b rgb=%h, expected 0/00", on, rgb); end
        probe(36, 11, 1'b1, on, rgb);
        checks++; if (on !== 1'b1 || rgb !== 8'hE0) begin errors++; $display("FAIL single_slot1_full: hud_on=%b rgb=%h, expected 1/e0", on, rgb); end
        for (int k = 1; k <= 60; k++) begin
            tick(3'd2);
            exp_flash = (k < 60);
            exp_full  = (k < 60) && (((k / 8) % 2) == 1);
            checks++; if (flash_active !== exp_flash) begin errors++; $display("FAIL single_flash_k%0d: flash_active=%b, expected %b", k, flash_active, exp_flash); end
            probe(52, 11, 1'b1, on, rgb);
            checks++; if (on !== exp_full || rgb !== (exp_full ? 8'hE0 : 8'h00)) begin errors++; $display("FAIL single_blink_k%0d: hud_on=%b rgb=%h, expected %b/%h", k, on, rgb, exp_full, exp_full ? 8'hE0 : 8'h00); end
            probe(51, 8, 1'b1, on, rgb);
            checks++; if (on !== 1'b1 || rgb !== 8'hFF) begin errors++; $display("FAIL single_outline_k%0d: hud_on=%b rgb=%h, expected 1/ff", k, on, rgb); end
        end
        tick(3'd2);
        checks++; if (flash_active !== 1'b0) begin errors++; $display("FAIL single_equal_no_flash: flash_active=%b, expected 0", flash_active); end
    endtask

    task automatic test_double_loss();
        logic on;
        logic [7:0] rgb;
        do_reset();
        tick(3'd1);
        checks++; if (flash_active !== 1'b1) begin errors++; $display("FAIL double_enter: flash_active=%b, expected 1", flash_active); end
        probe(36, 11, 1'b1, on, rgb);
        checks++; if (on !== 1'b0) begin errors++; $display("FAIL double_k0_slot1: hud_on=%b, expected 0", on); end
        probe(20, 11, 1'b1, on, rgb);
        checks++; if (on !== 1'b1 || rgb !== 8'hE0) begin errors++; $display("FAIL double_k0_slot0: hud_on=%b rgb=%h, expected 1/e0", on, rgb); end
        repeat (8) tick(3'd1);
        probe(36, 11, 1'b1, on, rgb);
        checks++; if (on !== 1'b1 || rgb !== 8'hE0) begin errors++; $display("FAIL double_k8_slot1: hud_on=%b rgb=%h, expected 1/e0", on, rgb); end
        probe(52, 11, 1'b1, on, rgb);
        checks++; if (on !== 1'b1 || rgb !== 8'hE0) begin errors++; $display("FAIL double_k8_slot2: hud_on=%b rgb=%h, expected 1/e0", on, rgb); end
        repeat (2) tick(3'd1);
        tick(3'd0);
        checks++; if (flash_active !== 1'b1) begin errors++; $display("FAIL double_drop_flash: flash_active=%b, expected 1", flash_active); end
        probe(20, 11, 1'b1, on, rgb);
        checks++; if (on !== 1'b0) begin errors++; $display("FAIL double_drop_slot0: hud_on=%b, expected 0", on); end
        probe(52, 11, 1'b1, on, rgb);
        checks++; if (on !== 1'b0) begin errors++; $display("FAIL double_drop_slot2: hud_on=%b, expected 0", on); end
        for (int k = 1; k <= 60; k++) begin
            tick(3'd0);
            if (k == 8) begin
                probe(20, 11, 1'b1, on, rgb);
                checks++; if (on !== 1'b1 || rgb !== 8'hE0) begin errors++; $display("FAIL double2_k8_slot0: hud_on=%b rgb=%h, expected 1/e0", on, rgb); end
                probe(52, 11, 1'b1, on, rgb);
                checks++; if (on !== 1'b1 || rgb !== 8'hE0) begin errors++; $display("FAIL double2_k8_slot2: hud_on=%b rgb=%h, expected 1/e0", on, rgb); end
            end
            if (k == 59) begin
                checks++; if (flash_active !== 1'b1) begin errors++; $display("FAIL double2_k59: flash_active=%b, expected 1", flash_active); end
            end
            if (k == 60) begin
                checks++; if (flash_active !== 1'b0) begin errors++; $display("FAIL double2_k60: flash_active=%b, expected 0", flash_active); end
                probe(20, 11, 1'b1, on, rgb);
                checks++; if (on !== 1'b0) begin errors++; $display("FAIL double2_end_slot0: hud_on=%b, expected 0", on); end
            end
        end
    endtask

    task automatic test_abort_clamp();
        logic on;
        logic [7:0] rgb;
        do_reset();
        tick(3'd2);
        repeat (3) tick(3'd2);
        checks++; if (flash_active !== 1'b1) begin errors++; $display("FAIL abort_pre: flash_active=%b, expected 1", flash_active); end
        tick(3'd3);
        checks++; if (flash_active !== 1'b0) begin errors++; $display("FAIL abort_flash: flash_active=%b, expected 0", flash_active); end
        probe(52, 11, 1'b1, on, rgb);
        checks++; if (on !== 1'b1 || rgb !== 8'hE0) begin errors++; $display("FAIL abort_slot2: hud_on=%b rgb=%h, expected 1/e0", on, rgb); end
        tick(3'd7);
        checks++; if (flash_active !== 1'b0) begin errors++; $display("FAIL clamp_no_flash: flash_active=%b, expected 0", flash_active); end
        probe(52, 11, 1'b1, on, rgb);
        checks++; if (on !== 1'b1 || rgb !== 8'hE0) begin errors++; $display("FAIL clamp_slot2: hud_on=%b rgb=%h, expected 1/e0", on, rgb); end
        tick(3'd1);
        tick(3'd7);
        checks++; if (flash_active !== 1'b0) begin errors++; $display("FAIL clamp_abort: flash_active=%b, expected 0", flash_active); end
        probe(52, 11, 1'b1, on, rgb);
        checks++; if (on !== 1'b1 || rgb !== 8'hE0) begin errors++; $display("FAIL clamp_abort_slot2: hud_on=%b rgb=%h, expected 1/e0", on, rgb); end
    endtask

    task automatic test_reset_mid_flash();
        logic on;
        logic [7:0] rgb;
        do_reset();
        tick(3'd1);
        repeat (20) tick(3'd1);
        checks++; if (flash_active !== 1'b1) begin errors++; $display("FAIL midrst_pre: flash_active=%b, expected 1", flash_active); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (flash_active !== 1'b0) begin errors++; $display("FAIL midrst_flash: flash_active=%b, expected 0", flash_active); end
        probe(52, 11, 1'b1, on, rgb);
        checks++; if (on !== 1'b1 || rgb !== 8'hE0) begin errors++; $display("FAIL midrst_slot2: hud_on=%b rgb=%h, expected 1/e0", on, rgb); end
        probe(36, 11, 1'b1, on, rgb);
        checks++; if (on !== 1'b1 || rgb !== 8'hE0) begin errors++; $display("FAIL midrst_slot1: hud_on=%b rgb=%h, expected 1/e0", on, rgb); end
        tick(3'd3);
        checks++; if (flash_active !== 1'b0) begin errors++; $display("FAIL midrst_no_spurious: flash_active=%b, expected 0", flash_active); end
        probe(52, 11, 1'b1, on, rgb);
        checks++; if (on !== 1'b1 || rgb !== 8'hE0) begin errors++; $display("FAIL midrst_after_tick: hud_on=%b rgb=%h, expected 1/e0", on, rgb); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_pixels();
        test_back_to_back();
        test_single_flash();
        test_double_loss();
        test_abort_clamp();
        test_reset_mid_flash();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
